div_seq: RTL and testbench
==========================

# div_seq

Sequenced signed/unsigned 32-bit divider for the eJ32 ALU, serving `idiv`/`irem` and their unsigned forms. The block sits between the ALU issue logic and the result writeback. It latches operands on a request, strips signs, and runs a radix-2 restoring magnitude core at one bit per cycle. It then restores Java-semantics signs and presents quotient and remainder with a one-cycle `done` pulse.

## Interface
- Parameters: none; data width fixed at DSZ = 32 from the shared eJ32 header.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  start request; sampled only in IDLE.
- `sgn`  in  1  1 = signed (two's complement), 0 = unsigned; sampled with `req`.
- `x`  in  32  dividend; sampled with `req`.
- `y`  in  32  divisor; sampled with `req`.
- `bsy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `q`, `r` and `dz` are valid in this cycle.
- `dz`  out  1  divide-by-zero flag, valid with `done`.
- `q`  out  32  quotient, held until the next accepted `req`.
- `r`  out  32  remainder, held until the next accepted `req`.

## Operation
- States and transitions:
  - IDLE: on `req`, go to ZCHK if `y==0`, otherwise to ABS.
  - ZCHK → IDLE.
  - ABS → ITER.
  - ITER (32 cycles) → FIX.
  - FIX → IDLE.
- IDLE:
  - On `req`, latch `x`, `y` and `sgn`.
  - Record `nq = sgn & (x[31]^y[31])` and `nr = sgn & x[31]`.
- ZCHK: set `q=0`, `r=0`, `dz=1`, `done=1`.
- ABS:
  - Compute magnitudes: `|x|` and `|y|` if `sgn` is set, raw values otherwise.
  - Load a 65-bit accumulator {33-bit partial remainder = 0, 32-bit dividend magnitude}.
  - Set the iteration counter to 31.
- ITER, each cycle:
  - Shift the accumulator left by 1.
  - Compute a 33-bit trial subtract of the partial remainder minus the divisor magnitude.
  - If the result is non-negative, commit the subtract and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter. Leave for FIX after the counter-0 iteration.
- FIX:
  - `q = nq ? -qmag : qmag`; `r = nr ? -rmag : rmag` (mod 2^32).
  - Set `dz=0` and `done=1`.
- Signed overflow: 0x80000000 / -1 yields `q=0x80000000`, `r=0`. This falls out naturally, since |0x80000000| is treated as unsigned 0x80000000. No special path.
- Sign rules (Java):
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - A zero result is never negated to a nonzero value.
- `req` while `bsy`: ignored, with no queuing. Operands may change freely after acceptance.
- Reset values: state IDLE, `bsy=0`, `done=0`, `dz=0`, `q=0`, `r=0`, counter 0, accumulator 0.
- `rst` mid-operation: abort immediately to the reset values. No `done` is ever issued for the aborted op.

## Timing
- `req` sampled at edge E0.
- Normal op:
  - ABS occupies the cycle after E0.
  - ITER occupies edges E1..E32 (32 edges).
  - FIX is at edge E33.
  - Edge E34 registers the results; `done=1` in the cycle after E34, i.e. 35 edges after the request.
- Divide-by-zero: `done=1`, `dz=1` in the cycle after E1.
- `bsy`: high from the cycle after E0 through the last cycle before `done`; low in the `done` cycle.
- Back-to-back: a `req` present in the `done` cycle is accepted, so the issue interval is 35 cycles.
- `done` is exactly one cycle wide. `q`/`r`/`dz` hold afterwards until the next acceptance.

## Test plan
- Signed basic: `sgn=1`, `x=7`, `y=-2` → `q=0xFFFFFFFD`, `r=1`. `x=-7`, `y=2` → `q=0xFFFFFFFD`, `r=0xFFFFFFFF`. `done` arrives exactly 35 cycles after `req`, with `bsy` high for 34 cycles.
- Overflow: `sgn=1`, `x=0x80000000`, `y=0xFFFFFFFF` → `q=0x80000000`, `r=0`, `dz=0`.
- Unsigned: `sgn=0`, `x=0xFFFFFFFF`, `y=0x10` → `q=0x0FFFFFFF`, `r=0xF`. Also `x=3`, `y=0xFFFFFFFF` → `q=0`, `r=3`.
- Divide by zero: `x=5`, `y=0` → `done` with `dz=1`, `q=0`, `r=0`, 2 edges after `req`. The next request (`10/3`) gives `q=3`, `r=1`, `dz=0`.
- Reset and busy: assert `rst` 10 cycles into a `100/7` op → `bsy`, `done`, `q` and `r` all go to 0 next cycle and no `done` follows. A `req` pulsed while `bsy` is ignored.
- Random: 10k random signed/unsigned operand pairs back-to-back, with `req` held high → results match the Java `/` and `%` reference model, one `done` per 35 cycles.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle between the ALU issue logic and the sequential divider.
interface div_if;
    logic        req;
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic        bsy;
    logic        done;
    logic        dz;
    logic [31:0] q;
    logic [31:0] r;

    modport master (output req, sgn, x, y, input bsy, done, dz, q, r);
    modport slave  (input req, sgn, x, y, output bsy, done, dz, q, r);
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider, one quotient bit per cycle, with Java idiv/irem
// sign handling; results come out with a one-cycle done pulse.
module div_seq (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int DSZ = 32;

    typedef enum logic [2:0] {IDLE, ZCHK, ABS, ITER, FIX} state_t;

    state_t             state;
    logic [DSZ-1:0]     xr, yr, dmag;
    logic               sr, nq, nr;
    logic [2*DSZ:0]     acc;
    logic [4:0]         cnt;
    logic               bsy, done, dz;
    logic [DSZ-1:0]     q, r;

    logic [DSZ-1:0]     xabs, yabs, qmag, rmag;
    logic [DSZ:0]       trial;
    logic               ge;

    assign xabs  = (sr && xr[DSZ-1]) ? -xr : xr;
    assign yabs  = (sr && yr[DSZ-1]) ? -yr : yr;

    // Trial subtract on the shifted partial remainder; the bit shifted out of
    // the top is always zero, but folding it into ge keeps the compare exact.
    assign trial = acc[2*DSZ-1:DSZ-1] - {1'b0, dmag};
    assign ge    = acc[2*DSZ] | ~trial[DSZ];

    assign qmag  = acc[DSZ-1:0];
    assign rmag  = acc[2*DSZ-1:DSZ];

    assign bus.bsy  = bsy;
    assign bus.done = done;
    assign bus.dz   = dz;
    assign bus.q    = q;
    assign bus.r    = r;

    // NOTE: every state register uses <= so all of them update from the same
    // pre-edge values; a blocking = here would leak new values into later lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            dmag  <= '0;
            sr    <= 1'b0;
            nq    <= 1'b0;
            nr    <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            bsy   <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        xr    <= bus.x;
                        yr    <= bus.y;
                        sr    <= bus.sgn;
                        nq    <= bus.sgn & (bus.x[DSZ-1] ^ bus.y[DSZ-1]);
                        nr    <= bus.sgn & bus.x[DSZ-1];
                        bsy   <= 1'b1;
                        state <= (bus.y == '0) ? ZCHK : ABS;
                    end
                end
                ZCHK: begin
                    q     <= '0;
                    r     <= '0;
                    dz    <= 1'b1;
                    done  <= 1'b1;
                    bsy   <= 1'b0;
                    state <= IDLE;
                end
                ABS: begin
                    dmag  <= yabs;
                    acc   <= {{(DSZ+1){1'b0}}, xabs};
                    cnt   <= 5'd31;
                    state <= ITER;
                end
                ITER: begin
                    acc <= ge ? {trial, acc[DSZ-2:0], 1'b1}
                              : {acc[2*DSZ-1:0], 1'b0};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= FIX;
                end
                FIX: begin
                    q     <= nq ? -qmag : qmag;
                    r     <= nr ? -rmag : rmag;
                    dz    <= 1'b0;
                    done  <= 1'b1;
                    bsy   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed vectors push expected results, and a
// negedge monitor pops and compares on every done pulse, including latency.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_if bus ();
    div_seq dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          t0;
        int          lat;
    } exp_t;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            check("done_pulse_width", {31'b0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("q",       bus.q, e.q);
                check("r",       bus.r, e.r);
                check("dz",      {31'b0, bus.dz}, {31'b0, e.dz});
                check("latency", cyc - e.t0, e.lat);
            end
        end
        prev_done = bus.done;
    end

    task automatic present(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input bit push);
        bus.sgn = s;
        bus.x   = a;
        bus.y   = b;
        bus.req = 1'b1;
        if (push)
            sb.push_back('{q: eq, r: er, dz: edz, t0: cyc + 1, lat: (edz ? 1 : 34)});
    endtask

    task automatic wait_done(output int nbsy);
        nbsy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
            if (bus.bsy === 1'b1) nbsy++;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected one within 60 cycles at cycle %0d", cyc);
    endtask

    task automatic single(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int ebsy);
        int nb;
        @(negedge clk);
        present(s, a, b, eq, er, edz, 1'b1);
        @(posedge clk);
        #1 bus.req = 1'b0;
        wait_done(nb);
        check("bsy_cycles", nb, ebsy);
        check("bsy_in_done", {31'b0, bus.bsy}, 32'd0);
        @(negedge clk);
        check("done_after_pulse", {31'b0, bus.done}, 32'd0);
        check("q_hold", bus.q, eq);
        check("r_hold", bus.r, er);
    endtask

    vec_t vecs[13];

    initial begin
        int nb;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vecs[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
        vecs[3]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[4]  = '{1'b1, 32'hFFFFFFFA,   32'd3,          32'hFFFFFFFE,   32'd0,          1'b0};
        vecs[5]  = '{1'b1, 32'd2,          32'hFFFFFFFB,   32'd0,          32'd2,          1'b0};
        vecs[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
        vecs[7]  = '{1'b0, 32'h12345678,   32'd1,          32'h12345678,   32'd0,          1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vecs[9]  = '{1'b1, 32'd7,          32'd0,          32'd0,          32'd0,          1'b1};
        vecs[10] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[11] = '{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
        vecs[12] = '{1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};

        bus.req = 1'b0;
        bus.sgn = 1'b0;
        bus.x   = '0;
        bus.y   = '0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bsy",  {31'b0, bus.bsy},  32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_dz",   {31'b0, bus.dz},   32'd0);
        check("rst_q",    bus.q, 32'd0);
        check("rst_r",    bus.r, 32'd0);
        rst = 1'b0;

        // Directed single operations
        single(1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34);
        single(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
        single(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34);
        single(1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0, 34);
        single(1'b0, 32'd3,        32'hFFFFFFFF, 32'd0,        32'd3,        1'b0, 34);
        single(1'b0, 32'd5,        32'd0,        32'd0,        32'd0,        1'b1, 1);
        single(1'b0, 32'd10,       32'd3,        32'd3,        32'd1,        1'b0, 34);

        // Reset 10 cycles into an op: outputs clear, no done ever follows
        @(negedge clk);
        present(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_bsy",  {31'b0, bus.bsy},  32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_q",    bus.q, 32'd0);
        check("abort_r",    bus.r, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_bsy", {31'b0, bus.bsy}, 32'd0);

        // A req pulse while busy must be ignored
        @(negedge clk);
        present(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b1);
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (5) @(negedge clk);
        present(1'b1, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1 bus.req = 1'b0;
        wait_done(nb);
        repeat (40) @(negedge clk);

        // Back-to-back with req held high; next operands appear in each done cycle
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            present(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz, 1'b1);
            @(posedge clk);
            #1;
            if (i == 12) bus.req = 1'b0;
            wait_done(nb);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
